// File: rtl/frame_slot_sched.sv
// Frame slot scheduler: hands ring-buffer slots to the frame writer and reader,
// keeping completed frames in an age-ordered queue of slot indices.
module frame_slot_sched #(
  parameter int unsigned START_ADDR       = 0,
  parameter int unsigned FRAMES_AMOUNT    = 3,
  parameter int unsigned FRAME_SIZE_B     = 4147200,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          OVERWRITE_OLDEST = 1'b0,
  localparam int unsigned SLOT_W          = $clog2(FRAMES_AMOUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_sof_i,
  input  logic                  wr_eof_i,
  input  logic                  wr_abort_i,
  output logic                  wr_active_o,
  output logic                  wr_drop_o,
  output logic [ADDR_WIDTH-1:0] wr_base_o,
  input  logic                  rd_sof_i,
  output logic                  rd_valid_o,
  output logic                  rd_repeat_o,
  output logic [ADDR_WIDTH-1:0] rd_base_o,
  output logic [SLOT_W:0]       ready_cnt_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int N = int'(FRAMES_AMOUNT);
  localparam logic [SLOT_W:0] CNT_ONE  = (SLOT_W+1)'(1);
  localparam logic [SLOT_W:0] CNT_FULL = (SLOT_W+1)'(FRAMES_AMOUNT);

  if (FRAMES_AMOUNT < 3) begin : g_param_check
    $error("frame_slot_sched: FRAMES_AMOUNT must be at least 3");
  end

  typedef enum logic [1:0] {SLOT_FREE, SLOT_WRITING, SLOT_READY, SLOT_READING} slot_state_e;

  slot_state_e           slot_q [N];
  slot_state_e           slot_d [N];
  logic [SLOT_W-1:0]     fifo_q [N];
  logic [SLOT_W-1:0]     fifo_d [N];
  logic [SLOT_W:0]       cnt_q, cnt_d;
  logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic                  wr_active_d, wr_drop_d, rd_valid_d, rd_repeat_d;
  logic [ADDR_WIDTH-1:0] wr_base_d, rd_base_d;
  logic [15:0]           drop_cnt_d;
  logic [N-1:0]          rd_released;
  logic                  fifo_ovf, take, lost_frame;
  logic [SLOT_W-1:0]     alloc_slot;

  function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [SLOT_W-1:0] s);
    return ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(FRAME_SIZE_B) * ADDR_WIDTH'(s);
  endfunction

  always_comb begin
    slot_d      = slot_q;
    fifo_d      = fifo_q;
    cnt_d       = cnt_q;
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    wr_active_d = wr_active_o;
    wr_drop_d   = wr_drop_o;
    wr_base_d   = wr_base_o;
    rd_valid_d  = rd_valid_o;
    rd_repeat_d = rd_repeat_o;
    rd_base_d   = rd_base_o;
    drop_cnt_d  = drop_cnt_o;
    rd_released = '0;
    fifo_ovf    = 1'b0;
    take        = 1'b0;
    alloc_slot  = '0;
    lost_frame  = 1'b0;

    // reader only sees the queue as it stood at the start of the cycle
    if (rd_sof_i) begin
      if (cnt_q != '0) begin
        if (rd_valid_o) begin
          slot_d[rd_slot_q]      = SLOT_FREE;
          rd_released[rd_slot_q] = 1'b1;
        end
        slot_d[fifo_q[0]] = SLOT_READING;
        rd_slot_d   = fifo_q[0];
        rd_base_d   = slot_base(fifo_q[0]);
        rd_valid_d  = 1'b1;
        rd_repeat_d = 1'b0;
        for (int i = 0; i < N-1; i++) fifo_d[i] = fifo_d[i+1];
        cnt_d = cnt_d - CNT_ONE;
      end else if (rd_valid_o) begin
        rd_repeat_d = 1'b1;
      end
    end

    // close the writer's frame: eof queues it, abort or a restarting sof frees it
    if (wr_active_o && (wr_eof_i || wr_abort_i || wr_sof_i)) begin
      wr_active_d = 1'b0;
      if (wr_eof_i && !wr_abort_i) begin
        slot_d[wr_slot_q] = SLOT_READY;
        if (cnt_d == CNT_FULL) begin
          fifo_ovf = 1'b1;
        end else begin
          for (int i = 0; i < N; i++) if (i == int'(cnt_d)) fifo_d[i] = wr_slot_q;
          cnt_d = cnt_d + CNT_ONE;
        end
      end else begin
        slot_d[wr_slot_q] = SLOT_FREE;
      end
    end

    // a slot the reader just released stays out of reach until next cycle
    if (wr_sof_i) begin
      for (int i = 0; i < N; i++) begin
        if (!take && slot_d[i] == SLOT_FREE && !rd_released[i]) begin
          take       = 1'b1;
          alloc_slot = SLOT_W'(i);
        end
      end
      if (!take && OVERWRITE_OLDEST && cnt_d != '0) begin
        take       = 1'b1;
        lost_frame = 1'b1;
        alloc_slot = fifo_d[0];
        for (int i = 0; i < N-1; i++) fifo_d[i] = fifo_d[i+1];
        cnt_d = cnt_d - CNT_ONE;
      end
      if (take) begin
        slot_d[alloc_slot] = SLOT_WRITING;
        wr_slot_d   = alloc_slot;
        wr_base_d   = slot_base(alloc_slot);
        wr_active_d = 1'b1;
        wr_drop_d   = 1'b0;
      end else begin
        wr_active_d = 1'b0;
        wr_drop_d   = 1'b1;
        lost_frame  = 1'b1;
      end
    end

    if (lost_frame && drop_cnt_o != 16'hFFFF) drop_cnt_d = drop_cnt_o + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= SLOT_FREE;
        fifo_q[i] <= '0;
      end
      cnt_q       <= '0;
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      wr_active_o <= 1'b0;
      wr_drop_o   <= 1'b0;
      wr_base_o   <= ADDR_WIDTH'(START_ADDR);
      rd_valid_o  <= 1'b0;
      rd_repeat_o <= 1'b0;
      rd_base_o   <= ADDR_WIDTH'(START_ADDR);
      drop_cnt_o  <= '0;
    end else begin
      slot_q      <= slot_d;
      fifo_q      <= fifo_d;
      cnt_q       <= cnt_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      wr_active_o <= wr_active_d;
      wr_drop_o   <= wr_drop_d;
      wr_base_o   <= wr_base_d;
      rd_valid_o  <= rd_valid_d;
      rd_repeat_o <= rd_repeat_d;
      rd_base_o   <= rd_base_d;
      drop_cnt_o  <= drop_cnt_d;
    end
  end

  assign ready_cnt_o = cnt_q;

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !fifo_ovf);

endmodule

// File: tb/tb_frame_slot_sched.sv
// Bench for frame_slot_sched: drop and overwrite variants side by side, checked
// every cycle against a queue-based model of the slot rules.
module tb_frame_slot_sched;

  localparam int     N   = 3;
  localparam longint FSZ = 4147200;
  localparam int S_FREE = 0, S_WR = 1, S_RDY = 2, S_RD = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic wr_sof = 1'b0, wr_eof = 1'b0, wr_abort = 1'b0, rd_sof = 1'b0;
  logic [1:0]  wr_active, wr_drop, rd_valid, rd_repeat;
  logic [31:0] wr_base [2];
  logic [31:0] rd_base [2];
  logic [2:0]  ready_cnt [2];
  logic [15:0] drop_cnt [2];

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  frame_slot_sched #(.OVERWRITE_OLDEST(1'b0)) u_dut_drop (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_sof_i(wr_sof), .wr_eof_i(wr_eof), .wr_abort_i(wr_abort),
    .wr_active_o(wr_active[0]), .wr_drop_o(wr_drop[0]), .wr_base_o(wr_base[0]),
    .rd_sof_i(rd_sof), .rd_valid_o(rd_valid[0]), .rd_repeat_o(rd_repeat[0]),
    .rd_base_o(rd_base[0]), .ready_cnt_o(ready_cnt[0]), .drop_cnt_o(drop_cnt[0])
  );

  frame_slot_sched #(.OVERWRITE_OLDEST(1'b1)) u_dut_ovw (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_sof_i(wr_sof), .wr_eof_i(wr_eof), .wr_abort_i(wr_abort),
    .wr_active_o(wr_active[1]), .wr_drop_o(wr_drop[1]), .wr_base_o(wr_base[1]),
    .rd_sof_i(rd_sof), .rd_valid_o(rd_valid[1]), .rd_repeat_o(rd_repeat[1]),
    .rd_base_o(rd_base[1]), .ready_cnt_o(ready_cnt[1]), .drop_cnt_o(drop_cnt[1])
  );

  // reference model state, index 0 = drop variant, 1 = overwrite variant
  int     m_st [2][N];
  int     m_q [2][$];
  int     m_wslot [2];
  int     m_rslot [2];
  bit     m_wa [2], m_wd [2], m_rv [2], m_rr [2];
  longint m_wb [2], m_rb [2];
  int     m_drops [2];

  function automatic longint base_of(int s);
    return longint'(s) * FSZ;
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) m_st[k][i] = S_FREE;
      m_q[k].delete();
      m_wslot[k] = -1; m_rslot[k] = -1;
      m_wa[k] = 0; m_wd[k] = 0; m_rv[k] = 0; m_rr[k] = 0;
      m_wb[k] = 0; m_rb[k] = 0; m_drops[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit s, bit e, bit a, bit r);
    int released;
    int pick;
    int head;
    released = -1;
    pick = -1;
    if (r) begin
      if (m_q[k].size() > 0) begin
        head = m_q[k].pop_front();
        if (m_rslot[k] >= 0) begin
          m_st[k][m_rslot[k]] = S_FREE;
          released = m_rslot[k];
        end
        m_st[k][head] = S_RD;
        m_rslot[k] = head;
        m_rv[k] = 1; m_rr[k] = 0; m_rb[k] = base_of(head);
      end else if (m_rslot[k] >= 0) begin
        m_rr[k] = 1;
      end
    end
    if (m_wslot[k] >= 0 && (s || e || a)) begin
      if (e && !a) begin
        m_st[k][m_wslot[k]] = S_RDY;
        m_q[k].push_back(m_wslot[k]);
      end else begin
        m_st[k][m_wslot[k]] = S_FREE;
      end
      m_wslot[k] = -1;
      m_wa[k] = 0;
    end
    if (s) begin
      for (int i = 0; i < N; i++)
        if (pick < 0 && m_st[k][i] == S_FREE && i != released) pick = i;
      if (pick < 0 && k == 1 && m_q[k].size() > 0) begin
        pick = m_q[k].pop_front();
        m_drops[k]++;
      end
      if (pick >= 0) begin
        m_st[k][pick] = S_WR;
        m_wslot[k] = pick;
        m_wa[k] = 1; m_wd[k] = 0; m_wb[k] = base_of(pick);
      end else begin
        m_wa[k] = 0; m_wd[k] = 1;
        m_drops[k]++;
      end
    end
  endtask

  task automatic check_all(string ph);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s d%0d wr_active", ph, k), longint'(wr_active[k]), longint'(m_wa[k]));
      chk($sformatf("%s d%0d wr_drop", ph, k), longint'(wr_drop[k]), longint'(m_wd[k]));
      chk($sformatf("%s d%0d wr_base", ph, k), longint'(wr_base[k]), m_wb[k]);
      chk($sformatf("%s d%0d rd_valid", ph, k), longint'(rd_valid[k]), longint'(m_rv[k]));
      chk($sformatf("%s d%0d rd_repeat", ph, k), longint'(rd_repeat[k]), longint'(m_rr[k]));
      chk($sformatf("%s d%0d rd_base", ph, k), longint'(rd_base[k]), m_rb[k]);
      chk($sformatf("%s d%0d ready_cnt", ph, k), longint'(ready_cnt[k]), longint'(m_q[k].size()));
      chk($sformatf("%s d%0d drop_cnt", ph, k), longint'(drop_cnt[k]),
          longint'(m_drops[k] > 65535 ? 65535 : m_drops[k]));
    end
  endtask

  // drive strobes for one clock, then compare both DUTs against the model
  task automatic cycle(bit s, bit e, bit a, bit r, string ph);
    wr_sof = s; wr_eof = e; wr_abort = a; rd_sof = r;
    @(posedge clk_i);
    #1;
    wr_sof = 0; wr_eof = 0; wr_abort = 0; rd_sof = 0;
    model_step(0, s, e, a, r);
    model_step(1, s, e, a, r);
    check_all(ph);
  endtask

  // asynchronous reset: outputs must clear before the next clock edge
  task automatic do_reset(string ph);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    int p_sof, p_eof, p_ab, p_rd;
    @(posedge clk_i);
    #1;
    do_reset("reset");
    chk("reset rd_base", longint'(rd_base[0]), 0);

    cycle(1, 0, 0, 0, "f0 sof");
    chk("f0 wr_base", longint'(wr_base[0]), 0);
    chk("f0 wr_active", longint'(wr_active[0]), 1);
    cycle(0, 1, 0, 0, "f0 eof");
    chk("f0 ready_cnt", longint'(ready_cnt[0]), 1);
    cycle(0, 0, 0, 1, "f0 rd");
    chk("f0 rd_valid", longint'(rd_valid[0]), 1);

    cycle(1, 0, 0, 0, "A sof");
    chk("A wr_base", longint'(wr_base[0]), 4147200);
    cycle(0, 1, 0, 0, "A eof");
    cycle(1, 0, 0, 0, "B sof");
    chk("B wr_base", longint'(wr_base[0]), 8294400);
    cycle(0, 1, 0, 0, "B eof");
    cycle(1, 0, 0, 0, "C sof");
    chk("C drop wr_drop", longint'(wr_drop[0]), 1);
    chk("C drop drop_cnt", longint'(drop_cnt[0]), 1);
    chk("C ovw wr_base", longint'(wr_base[1]), 4147200);
    chk("C ovw ready_cnt", longint'(ready_cnt[1]), 1);
    chk("C ovw drop_cnt", longint'(drop_cnt[1]), 1);
    cycle(0, 1, 0, 0, "C eof");
    chk("C eof keeps wr_drop", longint'(wr_drop[0]), 1);
    cycle(0, 0, 0, 1, "rd next");
    chk("rd next rd_base", longint'(rd_base[0]), 4147200);

    do_reset("reset2");
    cycle(1, 0, 0, 0, "rep sof");
    cycle(0, 1, 0, 0, "rep eof");
    cycle(0, 0, 0, 1, "rep rd1");
    cycle(0, 0, 0, 1, "rep rd2");
    chk("repeat flag", longint'(rd_repeat[0]), 1);
    chk("repeat rd_base", longint'(rd_base[0]), 0);

    do_reset("reset3");
    cycle(1, 0, 0, 0, "sim s0");
    cycle(0, 1, 0, 0, "sim e0");
    cycle(0, 0, 0, 1, "sim r0");
    cycle(1, 0, 0, 0, "sim s1");
    cycle(0, 1, 0, 0, "sim e1");
    cycle(1, 0, 0, 0, "sim s2");
    cycle(0, 1, 0, 0, "sim e2");
    cycle(1, 0, 0, 1, "sim both");
    chk("sim rd_base", longint'(rd_base[1]), 4147200);
    chk("sim wr_base", longint'(wr_base[1]), 8294400);
    chk("sim wr_active", longint'(wr_active[1]), 1);

    do_reset("reset4");
    cycle(1, 0, 0, 0, "ab s0");
    cycle(0, 1, 0, 0, "ab e0");
    cycle(1, 0, 0, 0, "ab s1");
    cycle(0, 1, 1, 0, "ab abort");
    chk("abort wr_active", longint'(wr_active[0]), 0);
    chk("abort ready_cnt", longint'(ready_cnt[0]), 1);
    cycle(1, 0, 0, 0, "ab realloc");
    chk("abort realloc base", longint'(wr_base[0]), 4147200);
    do_reset("mid rst");
    chk("mid rst wr_active", longint'(wr_active[0]), 0);

    for (int n = 0; n < 3000; n++) begin
      p_sof = $urandom_range(0, 99);
      p_eof = $urandom_range(0, 99);
      p_ab  = $urandom_range(0, 99);
      p_rd  = $urandom_range(0, 99);
      if ($urandom_range(0, 999) < 4) do_reset("rnd rst");
      else cycle(p_sof < 20, p_eof < 25, p_ab < 5, p_rd < 22, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
